// File: rtl/debug_slave_sysclk_cmdq.sv
// debug_slave_sysclk_cmdq
// System-clock side of the JTAG debug slave: synchronises the TCK-domain
// update strobes, captures the scanned shift register into a one-entry
// command buffer with a valid/ready handshake, and flags dropped commands.
module debug_slave_sysclk_cmdq #(
   parameter int DATA_W      = 38,
   parameter int IR_W        = 2,
   parameter int SYNC_STAGES = 2
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   vs_udr,
   input  logic                   vs_uir,
   input  logic [IR_W-1:0]        ir_in,
   input  logic [DATA_W-1:0]      sr,
   input  logic                   cmd_ready,
   input  logic                   overrun_clr,
   output logic [DATA_W-1:0]      jdo,
   output logic [IR_W-1:0]        cmd_ir,
   output logic                   cmd_valid,
   output logic [(2**IR_W)-1:0]   take_action,
   output logic                   uir_pulse,
   output logic                   overrun
);

   localparam int NUM_CH = 2**IR_W;

   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

   state_t                 state_q;
   state_t                 state_d;

   logic [SYNC_STAGES-1:0] sync_fill;
   logic [SYNC_STAGES-1:0] udr_sync;
   logic [SYNC_STAGES-1:0] uir_sync;
   logic                   udr_dly;
   logic                   uir_dly;
   logic                   udr_armed;
   logic                   uir_armed;
   logic                   udr_edge;
   logic                   uir_edge;
   logic                   udr_evt;
   logic                   uir_evt;
   logic                   capture;
   logic                   drop;

   // The synchroniser outputs only carry real samples once the chain has
   // been refilled after reset; before that their reset zeros must not arm
   // the edge detectors, otherwise a strobe held high through reset release
   // would look like a fresh rising edge.
   logic                   sync_valid;
   logic                   udr_level;
   logic                   uir_level;

   assign sync_valid = sync_fill[SYNC_STAGES-1];
   assign udr_level  = udr_sync[SYNC_STAGES-1];
   assign uir_level  = uir_sync[SYNC_STAGES-1];

   // Fill tracker: bit i becomes 1 once sync stage i holds a post-reset sample
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_fill <= '0;
      end else begin
         sync_fill <= {sync_fill[SYNC_STAGES-2:0], 1'b1};
      end
   end

   // Metastability chains bringing both strobes into the clk domain
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         udr_sync <= '0;
         uir_sync <= '0;
      end else begin
         udr_sync <= {udr_sync[SYNC_STAGES-2:0], vs_udr};
         uir_sync <= {uir_sync[SYNC_STAGES-2:0], vs_uir};
      end
   end

   assign udr_edge = udr_level & ~udr_dly & udr_armed;
   assign uir_edge = uir_level & ~uir_dly & uir_armed;

   // Edge history, arming on the first genuine low level, registered events
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         udr_dly   <= 1'b0;
         uir_dly   <= 1'b0;
         udr_armed <= 1'b0;
         uir_armed <= 1'b0;
         udr_evt   <= 1'b0;
         uir_evt   <= 1'b0;
      end else begin
         udr_dly   <= udr_level;
         uir_dly   <= uir_level;
         udr_armed <= udr_armed | (sync_valid & ~udr_level);
         uir_armed <= uir_armed | (sync_valid & ~uir_level);
         udr_evt   <= udr_edge;
         uir_evt   <= uir_edge;
      end
   end

   // Buffer state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   // Buffer next-state: capture into an empty or draining buffer, else drop
   always_comb begin
      state_d = state_q;
      capture = 1'b0;
      drop    = 1'b0;
      case (state_q)
         EMPTY: begin
            if (udr_evt) begin
               capture = 1'b1;
               state_d = FULL;
            end
         end
         FULL: begin
            if (udr_evt) begin
               if (cmd_ready) begin
                  capture = 1'b1;
               end else begin
                  drop = 1'b1;
               end
            end else if (cmd_ready) begin
               state_d = EMPTY;
            end
         end
         default: begin
            state_d = EMPTY;
         end
      endcase
   end

   assign cmd_valid = (state_q == FULL);

   // Command payload and per-channel action pulse
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         jdo         <= '0;
         cmd_ir      <= '0;
         take_action <= '0;
      end else begin
         take_action <= capture ? (NUM_CH'(1) << ir_in) : '0;
         if (capture) begin
            jdo    <= sr;
            cmd_ir <= ir_in;
         end
      end
   end

   // Sticky overrun; a drop in the same cycle as a clear keeps it set
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         overrun <= 1'b0;
      end else if (drop) begin
         overrun <= 1'b1;
      end else if (overrun_clr) begin
         overrun <= 1'b0;
      end
   end

   // IR-update pulse, aligned with the capture path latency
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         uir_pulse <= 1'b0;
      end else begin
         uir_pulse <= uir_evt;
      end
   end

endmodule

// File: tb/tb_debug_slave_sysclk_cmdq.sv
// Scoreboard bench for debug_slave_sysclk_cmdq: default instance plus a
// wider parameter set (IR_W=3, DATA_W=44, SYNC_STAGES=3).
module tb_debug_slave_sysclk_cmdq;

   typedef struct {
      int          cyc;
      logic [63:0] data;
      logic [7:0]  ir;
      logic [7:0]  act;
   } exp_t;

   logic clk = 1'b0;
   logic reset_n;
   int   cyc = 0;
   int   n_tests = 0;
   int   n_fail = 0;

   exp_t qa[$];
   exp_t qb[$];
   int   ua[$];
   int   ub[$];

   // instance A (defaults)
   logic        a_udr, a_uir, a_ready, a_clr;
   logic [1:0]  a_ir;
   logic [37:0] a_sr, a_jdo;
   logic [1:0]  a_cmd_ir;
   logic        a_valid, a_uirp, a_ovr;
   logic [3:0]  a_take;

   // instance B (param sweep)
   logic        b_udr, b_uir, b_ready, b_clr;
   logic [2:0]  b_ir;
   logic [43:0] b_sr, b_jdo;
   logic [2:0]  b_cmd_ir;
   logic        b_valid, b_uirp, b_ovr;
   logic [7:0]  b_take;

   debug_slave_sysclk_cmdq dut_a (
      .clk(clk), .reset_n(reset_n), .vs_udr(a_udr), .vs_uir(a_uir),
      .ir_in(a_ir), .sr(a_sr), .cmd_ready(a_ready), .overrun_clr(a_clr),
      .jdo(a_jdo), .cmd_ir(a_cmd_ir), .cmd_valid(a_valid),
      .take_action(a_take), .uir_pulse(a_uirp), .overrun(a_ovr)
   );

   debug_slave_sysclk_cmdq #(.DATA_W(44), .IR_W(3), .SYNC_STAGES(3)) dut_b (
      .clk(clk), .reset_n(reset_n), .vs_udr(b_udr), .vs_uir(b_uir),
      .ir_in(b_ir), .sr(b_sr), .cmd_ready(b_ready), .overrun_clr(b_clr),
      .jdo(b_jdo), .cmd_ir(b_cmd_ir), .cmd_valid(b_valid),
      .take_action(b_take), .uir_pulse(b_uirp), .overrun(b_ovr)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push_a(input int lat, input logic [63:0] d, input logic [7:0] ir, input logic [7:0] act);
      exp_t e;
      e.cyc = cyc + lat; e.data = d; e.ir = ir; e.act = act;
      qa.push_back(e);
   endtask

   task automatic push_b(input int lat, input logic [63:0] d, input logic [7:0] ir, input logic [7:0] act);
      exp_t e;
      e.cyc = cyc + lat; e.data = d; e.ir = ir; e.act = act;
      qb.push_back(e);
   endtask

   // Monitor A: every take_action / uir_pulse must match a queued expectation
   always @(negedge clk) begin
      exp_t e;
      int   u;
      if (a_take != '0) begin
         if (qa.size() == 0) begin
            check("a_unexpected_take_action", 64'(a_take), 64'd0);
         end else begin
            e = qa.pop_front();
            check("a_capture_cycle", 64'(cyc), 64'(e.cyc));
            check("a_jdo", 64'(a_jdo), e.data);
            check("a_cmd_ir", 64'(a_cmd_ir), 64'(e.ir));
            check("a_take_action", 64'(a_take), 64'(e.act));
            check("a_valid_on_capture", 64'(a_valid), 64'd1);
         end
      end
      if (a_uirp) begin
         if (ua.size() == 0) begin
            check("a_unexpected_uir_pulse", 64'(a_uirp), 64'd0);
         end else begin
            u = ua.pop_front();
            check("a_uir_cycle", 64'(cyc), 64'(u));
         end
      end
   end

   // Monitor B
   always @(negedge clk) begin
      exp_t e;
      int   u;
      if (b_take != '0) begin
         if (qb.size() == 0) begin
            check("b_unexpected_take_action", 64'(b_take), 64'd0);
         end else begin
            e = qb.pop_front();
            check("b_capture_cycle", 64'(cyc), 64'(e.cyc));
            check("b_jdo", 64'(b_jdo), e.data);
            check("b_cmd_ir", 64'(b_cmd_ir), 64'(e.ir));
            check("b_take_action", 64'(b_take), 64'(e.act));
         end
      end
      if (b_uirp) begin
         if (ub.size() == 0) begin
            check("b_unexpected_uir_pulse", 64'(b_uirp), 64'd0);
         end else begin
            u = ub.pop_front();
            check("b_uir_cycle", 64'(cyc), 64'(u));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   task automatic check_a_zero(input string tag);
      check({tag, "_jdo"}, 64'(a_jdo), 64'd0);
      check({tag, "_cmd_ir"}, 64'(a_cmd_ir), 64'd0);
      check({tag, "_valid"}, 64'(a_valid), 64'd0);
      check({tag, "_take"}, 64'(a_take), 64'd0);
      check({tag, "_uirp"}, 64'(a_uirp), 64'd0);
      check({tag, "_ovr"}, 64'(a_ovr), 64'd0);
   endtask

   initial begin
      reset_n = 1'b0;
      a_udr = 0; a_uir = 0; a_ready = 0; a_clr = 0; a_ir = '0; a_sr = '0;
      b_udr = 0; b_uir = 0; b_ready = 0; b_clr = 0; b_ir = '0; b_sr = '0;
      step(3);
      check_a_zero("reset");
      reset_n = 1'b1;
      step(8);
      check_a_zero("post_reset");

      // Capture: ir=1, latency SYNC_STAGES+1 edges after first sample
      a_ir = 2'd1; a_sr = 38'h2A_DEAD_BEEF;
      push_a(4, 64'h2A_DEAD_BEEF, 8'd1, 8'b0010);
      a_udr = 1'b1;
      step(4);
      a_udr = 1'b0;
      check("cap_valid", 64'(a_valid), 64'd1);
      step(3);
      check("cap_valid_held", 64'(a_valid), 64'd1);
      check("cap_take_one_cycle", 64'(a_take), 64'd0);

      // Handshake
      a_ready = 1'b1;
      step(1);
      a_ready = 1'b0;
      check("hs_valid_drop", 64'(a_valid), 64'd0);
      check("hs_jdo_kept", 64'(a_jdo), 64'h2A_DEAD_BEEF);

      // Fill buffer again, then drop a second command
      a_ir = 2'd2; a_sr = 38'h11_2233_4455;
      push_a(4, 64'h11_2233_4455, 8'd2, 8'b0100);
      a_udr = 1'b1; step(2); a_udr = 1'b0; step(4);
      check("ovr_pre_full", 64'(a_valid), 64'd1);
      a_ir = 2'd3; a_sr = 38'h1;
      a_udr = 1'b1; step(2); a_udr = 1'b0; step(4);
      check("ovr_jdo_kept", 64'(a_jdo), 64'h11_2233_4455);
      check("ovr_cmd_ir_kept", 64'(a_cmd_ir), 64'd2);
      check("ovr_set", 64'(a_ovr), 64'd1);
      check("ovr_valid", 64'(a_valid), 64'd1);

      // Third drop coincides with overrun_clr: set wins
      a_sr = 38'h2;
      a_udr = 1'b1; step(2); a_udr = 1'b0; step(1);
      a_clr = 1'b1; step(1); a_clr = 1'b0;
      check("ovr_set_wins", 64'(a_ovr), 64'd1);
      a_clr = 1'b1; step(1); a_clr = 1'b0;
      check("ovr_clear", 64'(a_ovr), 64'd0);

      // Back-to-back: new capture lands with cmd_ready high
      a_ir = 2'd0; a_sr = 38'h3F_0123_4567;
      push_a(4, 64'h3F_0123_4567, 8'd0, 8'b0001);
      a_udr = 1'b1; step(2); a_udr = 1'b0; step(1);
      a_ready = 1'b1; step(1); a_ready = 1'b0;
      check("b2b_valid", 64'(a_valid), 64'd1);
      check("b2b_jdo", 64'(a_jdo), 64'h3F_0123_4567);
      check("b2b_ovr", 64'(a_ovr), 64'd0);
      step(1);
      check("b2b_valid_held", 64'(a_valid), 64'd1);
      a_ready = 1'b1; step(1); a_ready = 1'b0;
      check("b2b_drain", 64'(a_valid), 64'd0);

      // cmd_ready while EMPTY has no effect
      a_ready = 1'b1; step(2); a_ready = 1'b0;
      check("empty_ready_ignored", 64'(a_valid), 64'd0);

      // uir pulse leaves the buffer alone
      ua.push_back(cyc + 4);
      a_uir = 1'b1; step(2); a_uir = 1'b0; step(4);
      check("uir_jdo_kept", 64'(a_jdo), 64'h3F_0123_4567);
      check("uir_valid", 64'(a_valid), 64'd0);
      check("uir_ovr", 64'(a_ovr), 64'd0);

      // Reset with FULL buffer and vs_udr held high through release
      a_ir = 2'd3; a_sr = 38'h00_CAFE_F00D;
      push_a(4, 64'h00_CAFE_F00D, 8'd3, 8'b1000);
      a_udr = 1'b1; step(5);
      check("rst_pre_full", 64'(a_valid), 64'd1);
      reset_n = 1'b0; step(2);
      check_a_zero("rst_mid");
      reset_n = 1'b1; step(8);
      check_a_zero("rst_held_high");
      a_udr = 1'b0; step(3);
      a_ir = 2'd1; a_sr = 38'h15_5555_AAAA;
      push_a(4, 64'h15_5555_AAAA, 8'd1, 8'b0010);
      a_udr = 1'b1; step(5); a_udr = 1'b0;
      check("rearm_valid", 64'(a_valid), 64'd1);
      check("rearm_jdo", 64'(a_jdo), 64'h15_5555_AAAA);

      // Param sweep: IR_W=3, DATA_W=44, SYNC_STAGES=3 -> latency edge +4
      b_ir = 3'd6; b_sr = 44'hABC_1234_5678;
      push_b(5, 64'hABC_1234_5678, 8'd6, 8'b0100_0000);
      b_udr = 1'b1; step(3); b_udr = 1'b0; step(3);
      check("sweep_valid", 64'(b_valid), 64'd1);
      ub.push_back(cyc + 5);
      b_uir = 1'b1; step(3); b_uir = 1'b0; step(4);
      check("sweep_ovr", 64'(b_ovr), 64'd0);
      check("sweep_jdo_kept", 64'(b_jdo), 64'hABC_1234_5678);

      step(6);
      check("a_pending_captures", 64'(qa.size()), 64'd0);
      check("b_pending_captures", 64'(qb.size()), 64'd0);
      check("a_pending_uir", 64'(ua.size()), 64'd0);
      check("b_pending_uir", 64'(ub.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/debug_slave_sysclk_cmdq.md
# debug_slave_sysclk_cmdq

Parametrised system-clock side of the Nios II JTAG debug slave. It synchronises the update-DR and update-IR strobes coming from the virtual-JTAG TCK domain and captures the scanned shift register into a one-entry command buffer. It decodes the captured IR into per-channel action pulses and holds each command until the CPU-side debug logic accepts it through a valid/ready handshake. A lost command is flagged as overrun rather than silently overwritten. It replaces the fixed 2-bit-IR, 38-bit, non-handshaked sysclk decoder used in the debug slave wrapper.

## Interface
- DATA_W, 38, width of the scanned shift register and of jdo.
- IR_W, 2, virtual-JTAG IR width; NUM_CH = 2**IR_W action channels.
- SYNC_STAGES, 2, synchroniser depth for vs_udr/vs_uir; legal values are 2 or more.

- clk  in  1  system clock; the only clock of the block.
- reset_n  in  1  asynchronous, active-low reset.
- vs_udr  in  1  virtual_state_udr level from the TCK domain; asynchronous to clk.
- vs_uir  in  1  virtual_state_uir level from the TCK domain; asynchronous to clk.
- ir_in  in  IR_W  virtual-JTAG IR; quasi-static while vs_udr is high.
- sr  in  DATA_W  TCK-domain shift register; stable from the vs_udr rise until the next capture.
- cmd_ready  in  1  consumer accepts the buffered command.
- overrun_clr  in  1  clears the overrun flag.
- jdo  out  DATA_W  captured shift-register contents.
- cmd_ir  out  IR_W  IR value captured together with jdo.
- cmd_valid  out  1  a command is buffered.
- take_action  out  NUM_CH  one-hot one-cycle pulse; bit cmd_ir fires on capture.
- uir_pulse  out  1  one-cycle pulse per synchronised vs_uir rise.
- overrun  out  1  sticky: a capture was dropped.

## Operation
- Each strobe passes through a SYNC_STAGES-flop chain, then a delay flop; edge = sync_last & ~delay.
- **Arming:** an `armed` flop per strobe resets to 0 and is set on the first cycle the synchronised level reads 0. Edges are ignored while not armed, so a strobe held high through reset release produces no event.
- **Buffer FSM, EMPTY:** on a udr edge:
  - jdo <= sr and cmd_ir <= ir_in.
  - take_action <= one-hot(ir_in).
  - Go to FULL; cmd_valid = 1.
- **Buffer FSM, FULL:**
  - cmd_valid & cmd_ready with no udr edge: go to EMPTY.
  - udr edge with cmd_ready = 1 in the same cycle: capture the new command as in EMPTY and stay FULL (back-to-back transfer).
  - udr edge with cmd_ready = 0: the new data is dropped; jdo, cmd_ir and take_action are unchanged; overrun <= 1.
- **overrun_clr:** clears overrun. If overrun_clr and a drop occur in the same cycle, set wins.
- **uir edge:** uir_pulse <= 1 for one cycle. It does not affect the buffer, jdo or overrun.
- cmd_ready while EMPTY is ignored.
- **Reset mid-operation:** a buffered command is discarded and the edge history is cleared. Arming is required again.

## Timing
- Reset values: jdo = 0, cmd_ir = 0, cmd_valid = 0, take_action = 0, uir_pulse = 0, overrun = 0, all sync/delay/armed flops = 0.
- Latency: when vs_udr is first sampled high at clk edge n, jdo/cmd_ir/cmd_valid/take_action update at edge n+SYNC_STAGES+1. Default: n+3.
- uir_pulse has the same latency as the udr capture path.
- take_action and uir_pulse are high for exactly one cycle.
- cmd_valid stays high until the cycle in which cmd_ready is high. It drops at the next edge unless a new capture lands at that same edge.
- All outputs are registered. There is no combinational path from cmd_ready to cmd_valid.
- Input requirement: vs_udr/vs_uir high and low phases each last at least 2 clk periods.

## Test plan
- **Capture:** after reset and arming, ir_in = 2'b01, sr = 38'h2A_DEAD_BEEF, pulse vs_udr high for 4 clocks, cmd_ready = 0 → at edge +3: jdo = 38'h2A_DEAD_BEEF, cmd_ir = 1, take_action = 4'b0010 for 1 cycle, cmd_valid = 1 and held.
- **Handshake:** hold cmd_valid, raise cmd_ready for 1 cycle → cmd_valid = 0 next edge; jdo retained.
- **Overrun:** buffer FULL with cmd_ready = 0, second vs_udr pulse with sr = 38'h1 → jdo unchanged, no take_action pulse, overrun = 1. Then overrun_clr together with a third dropped pulse → overrun stays 1. overrun_clr alone → overrun = 0.
- **Back-to-back:** new udr edge lands in the same cycle as cmd_ready = 1 → cmd_valid stays 1, jdo = new sr, one take_action pulse, overrun = 0.
- **Reset/arming:** assert reset_n = 0 with FULL buffer and vs_udr held high, then release with vs_udr still high → all outputs 0, no capture. vs_udr low for 3 clocks then high → exactly one capture.
- **Param sweep:** IR_W = 3, DATA_W = 44, SYNC_STAGES = 3; ir_in = 3'd6 → take_action = 8'b0100_0000 at edge +4; uir pulse → uir_pulse one cycle at +4.
